pc_gen: RTL and testbench

//  Parametrised fetch-address generator at the head of the IF stage.
//  - Produces the instruction-fetch PC and chip enable; drives the instruction-memory request with a valid/ready handshake.
//  - Redirect sources: flush (exception/eret), branch from ID, sequential PC+INST_BYTES.
//  - Buffers a branch redirect that arrives while fetch cannot advance, so no redirect is lost under stall or back-pressure.

---
 rtl/pc_gen_pkg.sv | 11 +
 rtl/pc_gen_if.sv | 10 +
 rtl/pc_redirect_buf.sv | 24 ++
 rtl/pc_gen.sv | 75 +++++++
 tb/tb_pc_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and FSM state encoding for the fetch-address generator
package pc_gen_pkg;
  typedef enum logic [1:0] {PC_IDLE, PC_BOOT, PC_RUN} pc_state_e;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic BRANCH       = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;
  localparam int   INST_BYTES   = 4;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: instruction-memory request bus (valid/ready handshake plus fetch address)
interface pc_gen_if #(parameter int ADDR_W = 32);
  logic              ce;
  logic              if_valid;
  logic              if_ready;
  logic              misalign_o;
  logic [ADDR_W-1:0] pc;
  modport master (output ce, if_valid, pc, misalign_o, input if_ready);
  modport slave  (input ce, if_valid, pc, misalign_o, output if_ready);
endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one branch redirect that could not be taken yet; load beats clear
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_target,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      target <= load_target;
    end else if (clear) begin
      valid  <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC generator with flush/branch redirect and pending-branch buffer.
// Optional PC_ALIGN_CHK_EN adds a registered misaligned-PC flag.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              INST_BYTES = pc_gen_pkg::INST_BYTES,
  parameter int              STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  pc_gen_if.master           imem
);
  pc_state_e         state, state_d;
  logic              ce, ce_d, adv, run, fl, br, ld, clr, pend_v;
  logic [ADDR_W-1:0] pc, pc_nx, pend_t;
  logic              unused_stall;
  assign unused_stall = ^stall;
  assign run = state == PC_RUN;
  assign adv = ce & (stall[0] == NO_STOP) & imem.if_ready;
  assign fl  = run & flush;
  assign br  = run & (branch_flag_i == BRANCH);
  always_comb begin
    state_d = state == PC_IDLE ? PC_BOOT : PC_RUN;
    ce_d    = CHIP_ENABLE;
  end
  always_comb begin
    pc_nx = fl         ? flush_pc
          : br & adv   ? branch_target_address_i
          : pend_v & adv ? pend_t
          : adv        ? pc + ADDR_W'(INST_BYTES)
          : pc;
    ld    = br & ~adv & ~fl;
    clr   = fl | (br & adv) | (pend_v & adv);
  end
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= PC_IDLE;
      ce    <= CHIP_DISABLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_d;
      ce    <= ce_d;
      pc    <= pc_nx;
    end
  end
  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (ld),
    .clear       (clr),
    .load_target (branch_target_address_i),
    .valid       (pend_v),
    .target      (pend_t)
  );
`ifdef PC_ALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) mis_q <= 1'b0;
    else mis_q <= (pc_nx % ADDR_W'(INST_BYTES)) != '0;
  end
  assign imem.misalign_o = mis_q & ce;
`else
  assign imem.misalign_o = 1'b0;
`endif
  assign imem.ce       = ce;
  assign imem.if_valid = ce;
  assign imem.pc       = pc;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen; inputs change and outputs are sampled on negedge
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = '0;
  int          asserts = 0;
  int          fails = 0;

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .flush_pc                (flush_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .imem                    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.if_ready = 1'b1;
    step();
    step();
    asserts++;
    if (bus.ce !== 1'b0 || bus.if_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ce: ce=%b valid=%b expected 0 0", bus.ce, bus.if_valid);
    end
    asserts++;
    if (bus.pc !== 32'h0 || bus.misalign_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_pc: pc=%h mis=%b expected 00000000 0", bus.pc, bus.misalign_o);
    end
  endtask

  task automatic test_boot();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++;
      if (bus.pc !== exp_pc[i] || bus.ce !== 1'b1 || bus.if_valid !== 1'b1) begin
        fails++;
        $display("FAIL boot[%0d]: pc=%h ce=%b valid=%b expected %h 1 1", i, bus.pc, bus.ce, bus.if_valid, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall_branch();
    stall[0] = 1'b1;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    step();
    step();
    asserts++;
    if (bus.pc !== 32'h8) begin
      fails++;
      $display("FAIL stall_hold: pc=%h expected 00000008", bus.pc);
    end
    stall[0] = 1'b0;
    step();
    asserts++;
    if (bus.pc !== 32'h100) begin
      fails++;
      $display("FAIL stall_pending: pc=%h expected 00000100", bus.pc);
    end
    step();
    asserts++;
    if (bus.pc !== 32'h104) begin
      fails++;
      $display("FAIL stall_after: pc=%h expected 00000104", bus.pc);
    end
  endtask

  task automatic test_flush_no_ready();
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h20;
    step();
    branch_target_address_i = 32'h300;
    bus.if_ready = 1'b0;
    step();
    branch_flag_i = 1'b0;
    asserts++;
    if (bus.pc !== 32'h20 || bus.if_valid !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_hold: pc=%h valid=%b expected 00000020 1", bus.pc, bus.if_valid);
    end
    flush = 1'b1;
    flush_pc = 32'h180;
    step();
    flush = 1'b0;
    asserts++;
    if (bus.pc !== 32'h180) begin
      fails++;
      $display("FAIL flush_no_accept: pc=%h expected 00000180", bus.pc);
    end
    step();
    asserts++;
    if (bus.pc !== 32'h180) begin
      fails++;
      $display("FAIL flush_hold: pc=%h expected 00000180", bus.pc);
    end
    bus.if_ready = 1'b1;
    step();
    asserts++;
    if (bus.pc !== 32'h184) begin
      fails++;
      $display("FAIL flush_clears_pending: pc=%h expected 00000184", bus.pc);
    end
  endtask

  task automatic test_newest_wins();
    bus.if_ready = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h40;
    step();
    asserts++;
    if (bus.pc !== 32'h184) begin
      fails++;
      $display("FAIL pending_hold: pc=%h expected 00000184", bus.pc);
    end
    bus.if_ready = 1'b1;
    branch_target_address_i = 32'h80;
    step();
    branch_flag_i = 1'b0;
    asserts++;
    if (bus.pc !== 32'h80) begin
      fails++;
      $display("FAIL newest_wins: pc=%h expected 00000080", bus.pc);
    end
    step();
    asserts++;
    if (bus.pc !== 32'h84) begin
      fails++;
      $display("FAIL old_pending_dropped: pc=%h expected 00000084", bus.pc);
    end
  endtask

  task automatic test_wrap_align();
    logic exp_mis;
`ifdef PC_ALIGN_CHK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'hFFFF_FFFC;
    step();
    branch_flag_i = 1'b0;
    asserts++;
    if (bus.pc !== 32'hFFFF_FFFC || bus.misalign_o !== 1'b0) begin
      fails++;
      $display("FAIL wrap_top: pc=%h mis=%b expected fffffffc 0", bus.pc, bus.misalign_o);
    end
    step();
    asserts++;
    if (bus.pc !== 32'h0) begin
      fails++;
      $display("FAIL wrap_zero: pc=%h expected 00000000", bus.pc);
    end
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h102;
    step();
    branch_flag_i = 1'b0;
    asserts++;
    if (bus.pc !== 32'h102 || bus.misalign_o !== exp_mis) begin
      fails++;
      $display("FAIL misalign_set: pc=%h mis=%b expected 00000102 %b", bus.pc, bus.misalign_o, exp_mis);
    end
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h200;
    step();
    branch_flag_i = 1'b0;
    asserts++;
    if (bus.pc !== 32'h200 || bus.misalign_o !== 1'b0) begin
      fails++;
      $display("FAIL misalign_clear: pc=%h mis=%b expected 00000200 0", bus.pc, bus.misalign_o);
    end
  endtask

  task automatic test_reset_pending();
    bus.if_ready = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h500;
    step();
    branch_flag_i = 1'b0;
    rst = 1'b1;
    step();
    asserts++;
    if (bus.pc !== 32'h0 || bus.ce !== 1'b0) begin
      fails++;
      $display("FAIL midreset: pc=%h ce=%b expected 00000000 0", bus.pc, bus.ce);
    end
    rst = 1'b0;
    bus.if_ready = 1'b1;
    step();
    asserts++;
    if (bus.pc !== 32'h0 || bus.ce !== 1'b1) begin
      fails++;
      $display("FAIL reboot: pc=%h ce=%b expected 00000000 1", bus.pc, bus.ce);
    end
    flush = 1'b1;
    flush_pc = 32'h700;
    step();
    flush = 1'b0;
    asserts++;
    if (bus.pc !== 32'h4) begin
      fails++;
      $display("FAIL boot_ignores_flush: pc=%h expected 00000004", bus.pc);
    end
    step();
    asserts++;
    if (bus.pc !== 32'h8) begin
      fails++;
      $display("FAIL pending_discarded: pc=%h expected 00000008", bus.pc);
    end
  endtask

  initial begin
    bus.if_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_boot();
    test_stall_branch();
    test_flush_no_ready();
    test_newest_wins();
    test_wrap_align();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
